// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle control sequencer.
//   - one-hot opcode encodings (OPC_ADD, OPC_SW, OPC_LW)
//   - ALU operation code ALU_ADD
//   - sequencer state enum mc_state_t
//   - instruction field extraction helpers
package mc_ctrl_pkg;

    localparam logic [5:0] OPC_ADD = 6'b000001;
    localparam logic [5:0] OPC_SW  = 6'b000010;
    localparam logic [5:0] OPC_LW  = 6'b000100;

    localparam logic [1:0] ALU_ADD = 2'b00;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } mc_state_t;

    function automatic logic [4:0] ir_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] ir_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] ir_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode classifier for the mc_ctrl sequencer.
// Ports:
//   ir       in  32 : instruction register contents
//   is_add   out 1  : opcode is ADD
//   is_sw    out 1  : opcode is SW
//   is_lw    out 1  : opcode is LW
//   illegal  out 1  : opcode is none of the above (incl. zero and multi-hot)
//   wr_sel   out 1  : write-back address select, 1 = rd (ADD), 0 = rt (LW)
module mc_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 6
) (
    input  logic [31:0] ir,
    output logic        is_add,
    output logic        is_sw,
    output logic        is_lw,
    output logic        illegal,
    output logic        wr_sel
);

    logic [OPC_W-1:0] opc;
    logic             ir_low_unused;

    always_comb begin
        opc           = ir[31 -: OPC_W];
        ir_low_unused = ^ir[31-OPC_W:0];
    end

    // Exact compares: only a single recognised one-hot code is legal.
    always_comb begin
        is_add  = (opc == OPC_W'(OPC_ADD));
        is_sw   = (opc == OPC_W'(OPC_SW));
        is_lw   = (opc == OPC_W'(OPC_LW));
        illegal = ~(is_add | is_sw | is_lw);
        wr_sel  = is_add;
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) for the
// single-issue processor datapath. Accepts one instruction over a
// valid/ready handshake, latches it in IR and drives register-file, ALU,
// memory and write-back controls for each state.
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   instr_valid/ready     : instruction handshake
//   instruction [31:0]    : opc[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0]
//   rs_addr, rt_addr      : register-file read addresses (from IR outside FETCH)
//   wr_addr, reg_write    : register-file write address / strobe (WB)
//   alu_src_imm, alu_op   : ALU operand-B select (EXEC) and operation (ADD)
//   mem_req, mem_we       : data-memory request / write (MEM)
//   mem_ack               : memory completion, honoured only in MEM
//   mem_to_reg            : write-back from memory data (LW in WB)
//   done, illegal, busy   : retire pulse, dropped-opcode pulse, not-in-FETCH
// Optional (macro MC_CTRL_PERF_EN):
//   retired_cnt, stall_cnt: retired instructions / MEM cycles without ack
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 6,
    parameter int unsigned RA_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instruction,
    output logic            instr_ready,
    output logic [RA_W-1:0] rs_addr,
    output logic [RA_W-1:0] rt_addr,
    output logic [RA_W-1:0] wr_addr,
    output logic            reg_write,
    output logic            alu_src_imm,
    output logic [1:0]      alu_op,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            mem_to_reg,
    output logic            done,
    output logic            illegal,
    output logic            busy
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    mc_state_t   state, nxt_state;
    logic [31:0] ir, nxt_ir;

    // Decode of the current IR drives state transitions.
    logic cur_add, cur_sw, cur_lw, cur_ill, cur_wr_sel_unused;
    // Decode of the next IR drives the registered outputs.
    logic nxt_add_unused, nxt_sw, nxt_lw, nxt_ill, nxt_wr_sel;

    mc_decode #(.OPC_W(OPC_W)) u_dec_cur (
        .ir      (ir),
        .is_add  (cur_add),
        .is_sw   (cur_sw),
        .is_lw   (cur_lw),
        .illegal (cur_ill),
        .wr_sel  (cur_wr_sel_unused)
    );

    mc_decode #(.OPC_W(OPC_W)) u_dec_nxt (
        .ir      (nxt_ir),
        .is_add  (nxt_add_unused),
        .is_sw   (nxt_sw),
        .is_lw   (nxt_lw),
        .illegal (nxt_ill),
        .wr_sel  (nxt_wr_sel)
    );

    logic cur_lw_unused;
    always_comb cur_lw_unused = cur_lw;

    // Next-state and next-IR logic.
    always_comb begin
        nxt_state = state;
        nxt_ir    = ir;
        unique case (state)
            FETCH: begin
                if (instr_valid) begin
                    nxt_state = DECODE;
                    nxt_ir    = instruction;
                end
            end
            DECODE:  nxt_state = cur_ill ? FETCH : EXEC;
            EXEC:    nxt_state = cur_add ? WB : MEM;
            MEM: begin
                if (mem_ack) begin
                    nxt_state = cur_sw ? FETCH : WB;
                end
            end
            WB:      nxt_state = FETCH;
            default: nxt_state = FETCH;
        endcase
    end

    // Outputs are a pure function of (state, IR). They are computed from
    // the next state/IR and registered, so after each edge they equal the
    // Moore decode of the registered state with no input-to-output path.
    logic            n_ready, n_busy, n_illegal, n_alu_src;
    logic            n_mem_req, n_mem_we, n_reg_write, n_mem_to_reg, n_done;
    logic [RA_W-1:0] n_rs, n_rt, n_wr;

    always_comb begin
        n_ready      = (nxt_state == FETCH);
        n_busy       = (nxt_state != FETCH);
        n_rs         = '0;
        n_rt         = '0;
        n_wr         = '0;
        n_illegal    = 1'b0;
        n_alu_src    = 1'b0;
        n_mem_req    = 1'b0;
        n_mem_we     = 1'b0;
        n_reg_write  = 1'b0;
        n_mem_to_reg = 1'b0;
        n_done       = 1'b0;
        if (nxt_state != FETCH) begin
            n_rs = RA_W'(ir_rs(nxt_ir));
            n_rt = RA_W'(ir_rt(nxt_ir));
        end
        unique case (nxt_state)
            DECODE: n_illegal = nxt_ill;
            EXEC:   n_alu_src = nxt_sw | nxt_lw;
            MEM: begin
                n_mem_req = 1'b1;
                n_mem_we  = nxt_sw;
            end
            WB: begin
                n_reg_write  = 1'b1;
                n_done       = 1'b1;
                n_mem_to_reg = nxt_lw;
                n_wr         = nxt_wr_sel ? RA_W'(ir_rd(nxt_ir))
                                          : RA_W'(ir_rt(nxt_ir));
            end
            default: ;
        endcase
    end

    logic wb_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            ir          <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            rs_addr     <= '0;
            rt_addr     <= '0;
            wr_addr     <= '0;
            illegal     <= 1'b0;
            alu_src_imm <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            reg_write   <= 1'b0;
            mem_to_reg  <= 1'b0;
            wb_done     <= 1'b0;
        end else begin
            state       <= nxt_state;
            ir          <= nxt_ir;
            instr_ready <= n_ready;
            busy        <= n_busy;
            rs_addr     <= n_rs;
            rt_addr     <= n_rt;
            wr_addr     <= n_wr;
            illegal     <= n_illegal;
            alu_src_imm <= n_alu_src;
            mem_req     <= n_mem_req;
            mem_we      <= n_mem_we;
            reg_write   <= n_reg_write;
            mem_to_reg  <= n_mem_to_reg;
            wb_done     <= n_done;
        end
    end

    // SW retires in its acknowledged MEM cycle, so that one done term
    // follows mem_ack combinationally; it is gated by the registered state.
    always_comb begin
        alu_op = ALU_ADD;
        done   = wb_done | ((state == MEM) & cur_sw & mem_ack);
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (done) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if ((state == MEM) && !mem_ack) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the single-issue processor datapath (register file, ALU, data memory). Accepts one 32-bit instruction at a time over a valid/ready handshake, latches it, and steps it through FETCH/DECODE/EXEC/MEM/WB. In each state it drives the register-file addresses, ALU controls, memory strobes and write-back strobes. Sits between the instruction source and the `processor` datapath. It replaces the datapath's implicit single-cycle control.

## Interface
- `OPC_W`, default 6: opcode field width, instruction bits [31:26].
- `RA_W`, default 5: register address width.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `instr_valid`  in  1: an instruction is offered.
- `instruction`  in  32: offered instruction. Fields: opc [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- `instr_ready`  out  1: the controller can accept an instruction.
- `rs_addr`, `rt_addr`  out  5: register-file read addresses.
- `wr_addr`  out  5: register-file write address.
- `reg_write`  out  1: register-file write strobe.
- `alu_src_imm`  out  1: ALU operand B is the sign-extended imm.
- `alu_op`  out  2: 00 = ADD. 01–11 are reserved and never driven.
- `mem_req`  out  1: data-memory access request.
- `mem_we`  out  1: the request is a write.
- `mem_ack`  in  1: memory has completed the current request.
- `mem_to_reg`  out  1: write-back source is the memory read data.
- `done`  out  1: one-cycle pulse when an instruction retires.
- `illegal`  out  1: one-cycle pulse when an unknown opcode is dropped.
- `busy`  out  1: the controller is not in FETCH.

## Operation
- Opcodes are one-hot:
  - ADD = 6'b000001: R[rd] = R[rs] + R[rt].
  - SW = 6'b000010: M[R[rs]+imm] = R[rt].
  - LW = 6'b000100: R[rt] = M[R[rs]+imm].
  - Any other value is illegal, including 0 and multi-hot values.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - `instr_ready` = 1.
  - On `instr_valid && instr_ready` at a rising edge: IR <= `instruction`, next state DECODE.
- DECODE:
  - `rs_addr` = IR.rs, `rt_addr` = IR.rt.
  - Legal opcode: next state EXEC.
  - Illegal opcode: pulse `illegal`, next state FETCH, IR unchanged, no strobes.
- EXEC:
  - `alu_op` = ADD.
  - `alu_src_imm` = 1 for SW and LW, 0 for ADD.
  - ADD goes to WB. SW and LW go to MEM.
- MEM:
  - `mem_req` = 1, `mem_we` = (opc == SW).
  - Stay in MEM while `mem_ack` = 0.
  - On `mem_ack`: SW goes to FETCH and pulses `done` in this same MEM cycle. LW goes to WB.
  - `mem_ack` outside MEM is ignored.
- WB:
  - `reg_write` = 1, `done` = 1.
  - `wr_addr` = IR.rd for ADD, IR.rt for LW.
  - `mem_to_reg` = 1 for LW only.
  - Next state FETCH.
- `rs_addr`/`rt_addr` come from IR in every state other than FETCH, so read data stays stable through EXEC, MEM and WB.
- All outputs are decoded from registered state and IR only. There is no combinational path from any input to any output, except that `done` in MEM for SW depends on `mem_ack`.
- Strobes not listed for a state are 0.

## Timing
- Reset: state = FETCH, IR = 0, counters = 0.
- Output values in reset: `instr_ready` = 1; every other output 0, including all addresses.
- Reset asserted mid-instruction aborts it. No strobe is issued after reset assertion; a pending `mem_req` drops immediately.
- Latency from acceptance edge to `done`, with `mem_ack` in the first MEM cycle:
  - ADD: 3 cycles (DECODE, EXEC, WB).
  - SW: 3 cycles.
  - LW: 4 cycles.
  - Each cycle of `mem_ack` = 0 adds one cycle.
- Back-to-back: `instr_ready` rises in the cycle after `done`. Issue interval is 4 cycles for ADD/SW and 5 for LW.
- `instr_valid` may stay high while not ready. The instruction is held off and not sampled.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - Adds `retired_cnt` out 32: increments on `done`.
  - Adds `stall_cnt` out 32: increments each MEM cycle with `mem_ack` = 0.
  - Both cleared by `rst` and wrap modulo 2^32.
- Macro undefined: both ports and registers are absent. All other behaviour is identical.

## Structure
- `mc_ctrl_pkg`: opcode localparams `OPC_ADD`, `OPC_SW`, `OPC_LW`; state enum `mc_state_t`; `ALU_ADD` constant.
- One sub-module, `mc_decode`, is combinational: IR -> {is_add, is_sw, is_lw, illegal, wr_sel}. The FSM lives in `mc_ctrl`.

## Test plan
- Reset, then offer 32'h0443_0800 (add $1,$2,$3). Expect:
  - `rs_addr` = 2, `rt_addr` = 3 from DECODE onward.
  - WB 3 cycles after acceptance with `reg_write` = 1, `wr_addr` = 1, `mem_to_reg` = 0, `done` pulse.
- 32'h0841_0000 (sw $1,0($2)) with `mem_ack` tied 1 -> `mem_req` = `mem_we` = 1 for exactly 1 cycle, `reg_write` never 1, `done` 3 cycles after acceptance.
- 32'h1044_0000 (lw $4,0($2)) with `mem_ack` delayed 3 cycles -> `mem_req` high 4 cycles with `mem_we` = 0, then WB with `wr_addr` = 4 and `mem_to_reg` = 1, `done` 7 cycles after acceptance; `stall_cnt` = 3 when `MC_CTRL_PERF_EN` is defined.
- Opcode 6'b000011 -> `illegal` pulses in DECODE, no `reg_write`/`mem_req`, `instr_ready` = 1 on the next cycle.
- Assert `rst` during MEM of LW -> `mem_req` falls without waiting for a clock edge, FETCH with all outputs at reset values, and the following ADD completes normally.
- Stream ADD, SW, LW with `instr_valid` held high -> acceptances 4, 4, 5 cycles apart; `retired_cnt` = 3.
